// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial N-bit subtractor built on one full-subtractor cell

// Single-bit combinational cell: computes a - b - bin.
module full_subtractor_beh (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Difference is the parity of the inputs. A borrow is needed when b
  // exceeds a, or when a equals b and a borrow is already pending.
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// Controller: shifts operands through the single cell LSB-first, one bit per
// clock, with the borrow held in a register between bits.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter value seen on the final RUN edge.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nx;

  // Working registers: operands drain out of bit 0, result fills in from the top.
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   res_sh;
  logic               brw;
  logic [CNT_W-1:0]   cnt;

  // Decoded per-cycle controls.
  logic               accept;
  logic               last;

  // Cell interface.
  logic               cell_diff;
  logic               cell_bout;
  logic [WIDTH-1:0]   res_next;

  // The one shared datapath cell.
  full_subtractor_beh u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (brw),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  // The new result bit enters at the MSB; a one-bit result is just the cell output.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign res_next = cell_diff;
    end else begin : g_res_wn
      assign res_next = {cell_diff, res_sh[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode. DONE accepts a new start directly so back-to-back
  // operations need no IDLE cycle in between.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST_BIT) begin
          state_nx = DONE;
          last     = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nx = RUN;
          accept   = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status flags follow the registered state, so nothing is combinational from inputs.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Serial datapath and result registers. The visible results only move on
  // the completing edge so they stay stable through IDLE and the next RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
      zero   <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      res_sh <= '0;
      brw    <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next;
      brw    <= cell_bout;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        diff <= res_next;
        bout <= cell_bout;
        zero <= (res_next == '0);
      end
    end
  end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor controller. Time-shares one `full_subtractor_beh` instance, processing operands LSB-first, one bit per clock, with the borrow carried in a register. Uses a start/busy/done handshake and holds registered results until the next accepted start. Serves as the area-minimal multi-bit subtract path built on the existing single-bit combinational cell.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- a  input  WIDTH  minuend; captured on an accepted start.
- b  input  WIDTH  subtrahend; captured on an accepted start.
- bin  input  1  borrow-in; captured on an accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; results are valid.
- diff  output  WIDTH  registered a - b - bin, modulo 2^WIDTH.
- bout  output  1  final borrow-out; 1 when a < b + bin (unsigned).
- zero  output  1  high when diff == 0; updated together with diff.

Behaviour:
- Reset, when rst_n = 0 at a clock edge:
  - state = IDLE.
  - busy, done, diff, bout and zero = 0.
  - Internal operand, result and borrow registers and bit counter = 0.
- The FSM has three states: IDLE, RUN and DONE.
- IDLE or DONE with start = 1 at edge T0:
  - Load a_sh = a, b_sh = b, brw = bin, cnt = 0, res_sh = 0.
  - Next state is RUN; busy = 1 and done = 0 after T0.
- IDLE with start = 0: stay in IDLE.
- DONE with start = 0: go to IDLE and clear done.
- RUN, at each edge T1..TWIDTH:
  - The datapath cell is driven with a = a_sh[0], b = b_sh[0], bin = brw.
  - res_sh <= {cell.diff, res_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by 1, filling with 0.
  - brw <= cell.bout; cnt <= cnt + 1.
- The RUN edge where cnt == WIDTH-1 (edge TWIDTH):
  - Loads diff <= {cell.diff, res_sh[WIDTH-1:1]}, bout <= cell.bout, and zero from the loaded diff value.
  - Next state is DONE; busy = 0 and done = 1.
- Latency: done is high in the cycle after edge T0+WIDTH. busy is high for exactly WIDTH cycles. Throughput is one operation per WIDTH+1 cycles with back-to-back starts.
- start during RUN is ignored. Inputs a, b and bin are don't-care outside the accepting edge.
- diff, bout and zero change only at the completing edge (or at reset). They hold their values through IDLE and through the next RUN.
- Reset mid-RUN: the abort takes effect at the next edge. There is no done pulse, and the outputs are cleared to 0.
- WIDTH = 1: a single RUN cycle; the result equals the full subtractor truth table.
- The cell is instantiated exactly once. No combinational path runs from inputs to outputs.

Test Plan:
1. WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse at T0 -> busy high for cycles T0+1..T0+8; done pulse at T0+9 with diff=0x1E, bout=0, zero=0.
2. WIDTH=8, a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=0 -> diff=0x00, bout=0, zero=1.
3. Hold start high continuously, with the operand sequence (0x10,0x01,0), (0x03,0x05,0) -> results 0x0F/bout 0, then 0xFE/bout 1. done pulses exactly 9 cycles apart; start in DONE is accepted, with no IDLE cycle.
4. Start an operation, then toggle start and change a, b and bin during RUN -> the running result is unaffected and no second operation begins; the result matches the originally captured operands.
5. Assert rst_n=0 for one edge at T0+4 during RUN -> the next cycle shows busy=0, done=0, diff=0, bout=0, zero=0 and state IDLE; no done pulse follows. A fresh start then completes normally.
6. Exhaustive sweep with WIDTH=1 over all 8 (a, b, bin) combinations -> diff and bout match the full subtractor truth table: 0/0, 1/1, 1/1, 0/1, 1/0, 0/0, 0/0, 1/1. done arrives 2 cycles after each start.
